// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-requester arbiter/sequencer for the single-port data memory (option: DMEM_ARB_ROUND_ROBIN_EN)
module dmem_arbiter #(
   parameter int AW = 14,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic          we0,
   input  logic          we1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata0,
   input  logic [DW-1:0] wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          done0,
   output logic          done1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic [AW-1:0] mem_address,
   output logic          mem_we,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state_q;
   logic   owner_q;
   logic   any_req;
   logic   pick1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic   last_q;
`endif

   // Choose which port wins if a grant happens this cycle
   always_comb begin
      any_req = req0 | req1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      // On a tie the port that was not granted last time wins
      pick1 = req1 & (~req0 | ~last_q);
`else
      pick1 = req1 & ~req0;
`endif
   end

   // Read data is only presented to the owner during its done cycle
   assign rdata0 = done0 ? mem_rdata : '0;
   assign rdata1 = done1 ? mem_rdata : '0;

   // Access sequencer: grant and latch in IDLE/RESP, drive the memory in ACCESS, respond in RESP
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         gnt0        <= 1'b0;
         gnt1        <= 1'b0;
         done0       <= 1'b0;
         done1       <= 1'b0;
         mem_we      <= 1'b0;
         mem_address <= '0;
         mem_wdata   <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         last_q      <= 1'b1;
`endif
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state_q)
            ACCESS: begin
               // Write landed on the mid-cycle negedge; read data is captured at this edge
               mem_we  <= 1'b0;
               done0   <= ~owner_q;
               done1   <= owner_q;
               state_q <= RESP;
            end
            default: begin
               // IDLE and RESP both accept a new request so back-to-back accesses take two cycles
               if (any_req) begin
                  state_q     <= ACCESS;
                  owner_q     <= pick1;
                  gnt0        <= ~pick1;
                  gnt1        <= pick1;
                  mem_we      <= pick1 ? we1 : we0;
                  mem_address <= pick1 ? addr1 : addr0;
                  mem_wdata   <= pick1 ? wdata1 : wdata0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                  last_q      <= pick1;
`endif
               end else begin
                  state_q <= IDLE;
                  mem_we  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0, req1, we0, we1;
   logic [13:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, done0, done1;
   logic [31:0] rdata0, rdata1;
   logic [13:0] mem_address;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks = 0;
   int fails  = 0;

   dmem_arbiter #(.AW(14), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_address(mem_address), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Single-port data memory: write on negedge, registered read on posedge
   logic [31:0] mem [0:16383];
   always @(negedge clk) if (mem_we) mem[mem_address] <= mem_wdata;
   always @(posedge clk) mem_rdata <= mem[mem_address];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
   endtask

   task automatic do_write(input int p, input logic [13:0] a, input logic [31:0] d);
      if (p == 0) begin req0 = 1'b1; we0 = 1'b1; addr0 = a; wdata0 = d; end
      else        begin req1 = 1'b1; we1 = 1'b1; addr1 = a; wdata1 = d; end
      cyc();
      idle_inputs();
      cyc();
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      cyc();
      cyc();
      checks++;
      if ({gnt0, gnt1, done0, done1, mem_we} !== 5'b0) begin
         fails++; $display("FAIL reset_ctrl got %b want 00000", {gnt0, gnt1, done0, done1, mem_we});
      end
      checks++;
      if (mem_address !== 14'h0 || mem_wdata !== 32'h0) begin
         fails++; $display("FAIL reset_mem got addr=%h wdata=%h want 0/0", mem_address, mem_wdata);
      end
      checks++;
      if (rdata0 !== 32'h0 || rdata1 !== 32'h0) begin
         fails++; $display("FAIL reset_rdata got %h/%h want 0/0", rdata0, rdata1);
      end
      rst = 1'b1;
      cyc();
      checks++;
      if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
         fails++; $display("FAIL idle_no_gnt got %b%b want 00", gnt0, gnt1);
      end
   endtask

   task automatic test_write_read();
      req0 = 1'b1; we0 = 1'b1; addr0 = 14'h0010; wdata0 = 32'hDEADBEEF;
      cyc();
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_we !== 1'b1 || mem_address !== 14'h0010 || mem_wdata !== 32'hDEADBEEF) begin
         fails++; $display("FAIL wr_gnt got gnt=%b%b we=%b addr=%h wd=%h want 10 1 0010 deadbeef",
                           gnt0, gnt1, mem_we, mem_address, mem_wdata);
      end
      idle_inputs();
      cyc();
      checks++;
      if (done0 !== 1'b1 || done1 !== 1'b0 || mem_we !== 1'b0 || rdata1 !== 32'h0 || rdata0 !== 32'hDEADBEEF) begin
         fails++; $display("FAIL wr_done got done=%b%b we=%b rd0=%h rd1=%h want 10 0 deadbeef 0",
                           done0, done1, mem_we, rdata0, rdata1);
      end
      cyc();
      req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0010;
      cyc();
      checks++;
      if (gnt0 !== 1'b1 || mem_we !== 1'b0 || done0 !== 1'b0) begin
         fails++; $display("FAIL rd_gnt got gnt0=%b we=%b done0=%b want 1 0 0", gnt0, mem_we, done0);
      end
      idle_inputs();
      cyc();
      checks++;
      if (done0 !== 1'b1 || rdata0 !== 32'hDEADBEEF || done1 !== 1'b0 || rdata1 !== 32'h0) begin
         fails++; $display("FAIL rd_done got done0=%b rd0=%h done1=%b rd1=%h want 1 deadbeef 0 0",
                           done0, rdata0, done1, rdata1);
      end
      cyc();
      checks++;
      if (done0 !== 1'b0 || rdata0 !== 32'h0) begin
         fails++; $display("FAIL rd_after got done0=%b rd0=%h want 0 0", done0, rdata0);
      end
   endtask

   task automatic test_tie();
      do_write(0, 14'h0001, 32'hA5A50001);
      do_write(1, 14'h0002, 32'h5A5A0002);
      req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0001;
      req1 = 1'b1; we1 = 1'b0; addr1 = 14'h0002;
      cyc();
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
         fails++; $display("FAIL tie_gnt got %b%b want 10", gnt0, gnt1);
      end
      req0 = 1'b0;
      cyc();
      checks++;
      if (done0 !== 1'b1 || rdata0 !== 32'hA5A50001 || done1 !== 1'b0 || gnt1 !== 1'b0) begin
         fails++; $display("FAIL tie_done0 got done=%b%b rd0=%h gnt1=%b want 10 a5a50001 0",
                           done0, done1, rdata0, gnt1);
      end
      cyc();
      checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || done0 !== 1'b0) begin
         fails++; $display("FAIL tie_gnt1 got gnt=%b%b done0=%b want 01 0", gnt0, gnt1, done0);
      end
      req1 = 1'b0;
      cyc();
      checks++;
      if (done1 !== 1'b1 || rdata1 !== 32'h5A5A0002 || rdata0 !== 32'h0 || done0 !== 1'b0) begin
         fails++; $display("FAIL tie_done1 got done=%b%b rd1=%h rd0=%h want 01 5a5a0002 0",
                           done0, done1, rdata1, rdata0);
      end
      idle_inputs();
      cyc();
   endtask

   task automatic test_starve();
      int g0 = 0;
      int g1 = 0;
      int first_done1 = -1;
      int prev = -1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 14'h0001;
      req1 = 1'b1; we1 = 1'b0; addr1 = 14'h0002;
      for (int c = 0; c < 40; c++) begin
         cyc();
         if (gnt0) g0++;
         if (gnt1) g1++;
         if (done1 && first_done1 < 0) first_done1 = c + 1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         if (gnt0 || gnt1) begin
            if (prev >= 0) begin
               checks++;
               if (int'(gnt1) == prev) begin
                  fails++; $display("FAIL rr_alternate cycle %0d got port %0d again want other", c, prev);
               end
            end
            prev = int'(gnt1);
         end
`endif
      end
      checks++;
      if (g0 + g1 != 20) begin
         fails++; $display("FAIL starve_count got %0d grants want 20", g0 + g1);
      end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      checks++;
      if (first_done1 < 1 || first_done1 > 4) begin
         fails++; $display("FAIL rr_done1_latency got %0d cycles want 1..4", first_done1);
      end
`else
      checks++;
      if (g1 != 0 || prev != -1) begin
         fails++; $display("FAIL fixed_starve got gnt1 count %0d want 0", g1);
      end
`endif
      idle_inputs();
      cyc();
      cyc();
   endtask

   task automatic test_reset_mid();
      req1 = 1'b1; we1 = 1'b1; addr1 = 14'h3FFF; wdata1 = 32'h12345678;
      cyc();
      checks++;
      if (gnt1 !== 1'b1 || mem_we !== 1'b1 || mem_address !== 14'h3FFF) begin
         fails++; $display("FAIL rstmid_gnt got gnt1=%b we=%b addr=%h want 1 1 3fff", gnt1, mem_we, mem_address);
      end
      idle_inputs();
      rst = 1'b0;
      cyc();
      checks++;
      if ({gnt0, gnt1, done0, done1, mem_we} !== 5'b0 || mem_address !== 14'h0 || mem_wdata !== 32'h0 || rdata1 !== 32'h0) begin
         fails++; $display("FAIL rstmid_outs got ctl=%b addr=%h wd=%h rd1=%h want 0s",
                           {gnt0, gnt1, done0, done1, mem_we}, mem_address, mem_wdata, rdata1);
      end
      rst = 1'b1;
      cyc();
      checks++;
      if (done1 !== 1'b0) begin
         fails++; $display("FAIL rstmid_nodone got done1=%b want 0", done1);
      end
      req0 = 1'b1; we0 = 1'b0; addr0 = 14'h3FFF;
      cyc();
      idle_inputs();
      cyc();
      checks++;
      if (done0 !== 1'b1 || rdata0 !== 32'h12345678) begin
         fails++; $display("FAIL rstmid_readback got done0=%b rd0=%h want 1 12345678", done0, rdata0);
      end
      cyc();
   endtask

   task automatic test_withdraw();
      req0 = 1'b1; we0 = 1'b1; addr0 = 14'h0020; wdata0 = 32'hCAFE0020;
      cyc();
      checks++;
      if (gnt0 !== 1'b1) begin
         fails++; $display("FAIL wd_gnt0 got %b want 1", gnt0);
      end
      req0 = 1'b0; we0 = 1'b0;
      req1 = 1'b1; we1 = 1'b1; addr1 = 14'h0055; wdata1 = 32'hBAD00055;
      for (int c = 0; c < 6; c++) begin
         cyc();
         if (c == 0) idle_inputs();
         checks++;
         if (gnt1 !== 1'b0 || (mem_we === 1'b1 && mem_address === 14'h0055)) begin
            fails++; $display("FAIL wd_no_access cycle %0d got gnt1=%b we=%b addr=%h want no port-1 access",
                              c, gnt1, mem_we, mem_address);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] sh [int];
      logic        r_req [2];
      logic        r_we [2];
      logic [13:0] r_addr [2];
      logic [31:0] r_wd [2];
      int          gap [2];
      int          gprev = -1;
      int          exp_g;
      logic [31:0] pend = '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      int          last_g = 1;
`endif
      rst = 1'b0;
      idle_inputs();
      cyc();
      rst = 1'b1;
      for (int p = 0; p < 2; p++) begin
         r_req[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_wd[p] = '0;
         gap[p] = $urandom_range(0, 2);
      end
      for (int n = 0; n < 600; n++) begin
         cyc();
         // Expected: grant possible only if no grant at the previous edge; done follows grant by one edge
         exp_g = -1;
         if (gprev < 0 && (r_req[0] || r_req[1])) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            if (r_req[0] && r_req[1]) exp_g = (last_g == 1) ? 0 : 1;
            else                      exp_g = r_req[1] ? 1 : 0;
            last_g = exp_g;
`else
            exp_g = r_req[0] ? 0 : 1;
`endif
         end
         checks++;
         if (gnt0 !== (exp_g == 0) || gnt1 !== (exp_g == 1)) begin
            fails++; $display("FAIL rnd_gnt cycle %0d got %b%b want port %0d", n, gnt0, gnt1, exp_g);
         end
         checks++;
         if (done0 !== (gprev == 0) || done1 !== (gprev == 1)) begin
            fails++; $display("FAIL rnd_done cycle %0d got %b%b want port %0d", n, done0, done1, gprev);
         end
         checks++;
         if (gprev == 0 && (rdata0 !== pend || rdata1 !== 32'h0)) begin
            fails++; $display("FAIL rnd_rdata0 cycle %0d got %h/%h want %h/0", n, rdata0, rdata1, pend);
         end else if (gprev == 1 && (rdata1 !== pend || rdata0 !== 32'h0)) begin
            fails++; $display("FAIL rnd_rdata1 cycle %0d got %h/%h want 0/%h", n, rdata0, rdata1, pend);
         end else if (gprev < 0 && (rdata0 !== 32'h0 || rdata1 !== 32'h0)) begin
            fails++; $display("FAIL rnd_rdata_idle cycle %0d got %h/%h want 0/0", n, rdata0, rdata1);
         end
         checks++;
         if (exp_g >= 0) begin
            if (mem_we !== r_we[exp_g] || mem_address !== r_addr[exp_g] || (r_we[exp_g] && mem_wdata !== r_wd[exp_g])) begin
               fails++; $display("FAIL rnd_mem cycle %0d got we=%b addr=%h wd=%h want %b %h %h",
                                 n, mem_we, mem_address, mem_wdata, r_we[exp_g], r_addr[exp_g], r_wd[exp_g]);
            end
            if (r_we[exp_g]) begin
               sh[int'(r_addr[exp_g])] = r_wd[exp_g];
               pend = r_wd[exp_g];
            end else begin
               pend = sh[int'(r_addr[exp_g])];
            end
         end else if (mem_we !== 1'b0) begin
            fails++; $display("FAIL rnd_mem_we cycle %0d got %b want 0", n, mem_we);
         end
         gprev = exp_g;
         // Requesters: hold until granted, occasionally withdraw, then pause a random gap
         for (int p = 0; p < 2; p++) begin
            if (exp_g == p) begin
               r_req[p] = 1'b0;
               gap[p] = $urandom_range(0, 3);
            end else if (r_req[p] && $urandom_range(0, 19) == 0) begin
               r_req[p] = 1'b0;
               gap[p] = 1;
            end
            if (!r_req[p]) begin
               if (gap[p] == 0) begin
                  r_req[p] = 1'b1;
                  r_addr[p] = ($urandom_range(0, 7) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
                  r_we[p] = !sh.exists(int'(r_addr[p])) || ($urandom_range(0, 1) == 1);
                  r_wd[p] = $urandom;
               end else begin
                  gap[p]--;
               end
            end
         end
         req0 = r_req[0]; we0 = r_we[0]; addr0 = r_addr[0]; wdata0 = r_wd[0];
         req1 = r_req[1]; we1 = r_we[1]; addr1 = r_addr[1]; wdata1 = r_wd[1];
      end
      idle_inputs();
      cyc();
      cyc();
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      test_reset();
      test_write_read();
      test_tie();
      test_starve();
      test_reset_mid();
      test_withdraw();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
